// File: rtl/axi4_slave_pkg.sv
// Shared types and constants for the AXI4 burst slave memory.
package axi4_slave_pkg;

  localparam int MEM_DEPTH_DFLT = 64;
  localparam int MEM_AW         = $clog2(MEM_DEPTH_DFLT);

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_SLVERR = 2'b10
  } resp_t;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
  } wr_state_t;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } rd_state_t;

endpackage

// File: rtl/axi_slv_word_ram.sv
// Word array with one byte-enabled write port and one asynchronous read port.
// Contents are deliberately not reset so data survives a bus reset.
module axi_slv_word_ram #(
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic [3:0]    we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (we[b]) mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
    end
  end

  // Read is combinational; a same-edge write is seen by the sampler as the old word.
  assign rdata = mem[raddr];

endmodule

// File: rtl/axi4_burst_slave_mem.sv
// AXI4 INCR-burst slave backed by a word RAM; independent single-outstanding write and read paths.
//
// state  | meaning
// W_IDLE | awready high, waiting for a write burst address
// W_DATA | wready high, accepting beats until the latched beat count expires
// W_RESP | bvalid high, holding the response until bready
// R_IDLE | arready high, waiting for a read burst address
// R_DATA | rvalid high, presenting one word per handshake until the last beat
module axi4_burst_slave_mem
  import axi4_slave_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 32,
  parameter int MEM_DEPTH          = MEM_DEPTH_DFLT
) (
  input  logic                            s00_axi_aclk,
  input  logic                            s00_axi_aresetn,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_awaddr,
  input  logic [7:0]                      s00_axi_awlen,
  input  logic                            s00_axi_awvalid,
  output logic                            s00_axi_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s00_axi_wstrb,
  input  logic                            s00_axi_wlast,
  input  logic                            s00_axi_wvalid,
  output logic                            s00_axi_wready,
  output logic [1:0]                      s00_axi_bresp,
  output logic                            s00_axi_bvalid,
  input  logic                            s00_axi_bready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_araddr,
  input  logic [7:0]                      s00_axi_arlen,
  input  logic                            s00_axi_arvalid,
  output logic                            s00_axi_arready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_rdata,
  output logic [1:0]                      s00_axi_rresp,
  output logic                            s00_axi_rlast,
  output logic                            s00_axi_rvalid,
  input  logic                            s00_axi_rready
);

  localparam int IDX_W = $clog2(MEM_DEPTH);

  wr_state_t        wr_state, wr_state_nxt;
  rd_state_t        rd_state, rd_state_nxt;
  logic [IDX_W-1:0] wr_idx, rd_idx, ram_raddr;
  logic [7:0]       wr_rem, rd_rem;
  logic             wr_err;
  logic [31:0]      ram_rdata, rd_data_q;
  logic [3:0]       ram_we;
  logic             aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic             unused_addr_bits;

  // The interconnect decodes the upper bits; byte offset is implied by full-width beats.
  assign unused_addr_bits = ^{s00_axi_awaddr[C_S_AXI_ADDR_WIDTH-1:IDX_W+2], s00_axi_awaddr[1:0],
                              s00_axi_araddr[C_S_AXI_ADDR_WIDTH-1:IDX_W+2], s00_axi_araddr[1:0]};

  assign aw_hs = s00_axi_awvalid && s00_axi_awready;
  assign w_hs  = s00_axi_wvalid  && s00_axi_wready;
  assign b_hs  = s00_axi_bvalid  && s00_axi_bready;
  assign ar_hs = s00_axi_arvalid && s00_axi_arready;
  assign r_hs  = s00_axi_rvalid  && s00_axi_rready;

  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) wr_state <= W_IDLE;
    else                  wr_state <= wr_state_nxt;
  end

  always_comb begin
    wr_state_nxt    = wr_state;
    s00_axi_awready = 1'b0;
    s00_axi_wready  = 1'b0;
    s00_axi_bvalid  = 1'b0;
    case (wr_state)
      W_IDLE: begin
        s00_axi_awready = 1'b1;
        if (s00_axi_awvalid) wr_state_nxt = W_DATA;
      end
      W_DATA: begin
        s00_axi_wready = 1'b1;
        if (s00_axi_wvalid && wr_rem == 8'd0) wr_state_nxt = W_RESP;
      end
      W_RESP: begin
        s00_axi_bvalid = 1'b1;
        if (s00_axi_bready) wr_state_nxt = W_IDLE;
      end
      default: wr_state_nxt = W_IDLE;
    endcase
  end

  // Beat count alone ends the burst; a misplaced wlast only taints the response.
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      wr_idx <= '0;
      wr_rem <= '0;
      wr_err <= 1'b0;
    end else begin
      if (aw_hs) begin
        wr_idx <= s00_axi_awaddr[IDX_W+1:2];
        wr_rem <= s00_axi_awlen;
      end
      if (w_hs) begin
        wr_idx <= wr_idx + IDX_W'(1);
        wr_rem <= wr_rem - 8'd1;
        if (s00_axi_wlast != (wr_rem == 8'd0)) wr_err <= 1'b1;
      end
      if (b_hs) wr_err <= 1'b0;
    end
  end

  assign ram_we        = w_hs ? s00_axi_wstrb : 4'b0000;
  assign s00_axi_bresp = (s00_axi_bvalid && wr_err) ? RESP_SLVERR : RESP_OKAY;

  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) rd_state <= R_IDLE;
    else                  rd_state <= rd_state_nxt;
  end

  always_comb begin
    rd_state_nxt    = rd_state;
    s00_axi_arready = 1'b0;
    s00_axi_rvalid  = 1'b0;
    case (rd_state)
      R_IDLE: begin
        s00_axi_arready = 1'b1;
        if (s00_axi_arvalid) rd_state_nxt = R_DATA;
      end
      R_DATA: begin
        s00_axi_rvalid = 1'b1;
        if (s00_axi_rready && rd_rem == 8'd0) rd_state_nxt = R_IDLE;
      end
      default: rd_state_nxt = R_IDLE;
    endcase
  end

  // In R_IDLE the RAM looks at the incoming start index so beat 0 is ready one cycle after AR.
  assign ram_raddr = (rd_state == R_IDLE) ? s00_axi_araddr[IDX_W+1:2] : rd_idx + IDX_W'(1);

  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      rd_idx    <= '0;
      rd_rem    <= '0;
      rd_data_q <= '0;
    end else if (ar_hs) begin
      rd_idx    <= s00_axi_araddr[IDX_W+1:2];
      rd_rem    <= s00_axi_arlen;
      rd_data_q <= ram_rdata;
    end else if (r_hs && rd_rem != 8'd0) begin
      rd_idx    <= ram_raddr;
      rd_rem    <= rd_rem - 8'd1;
      rd_data_q <= ram_rdata;
    end
  end

  assign s00_axi_rdata = rd_data_q;
  assign s00_axi_rresp = RESP_OKAY;
  assign s00_axi_rlast = s00_axi_rvalid && (rd_rem == 8'd0);

  axi_slv_word_ram #(
    .DEPTH (MEM_DEPTH),
    .AW    (IDX_W)
  ) u_ram (
    .clk   (s00_axi_aclk),
    .we    (ram_we),
    .waddr (wr_idx),
    .wdata (s00_axi_wdata),
    .raddr (ram_raddr),
    .rdata (ram_rdata)
  );

endmodule

// File: tb/tb_axi4_burst_slave_mem.sv
// Bench for axi4_burst_slave_mem: randomized bursts checked against a word-array model.
module tb_axi4_burst_slave_mem;

  localparam int DEPTH = 64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] awaddr = '0, araddr = '0, wdata = '0;
  logic [7:0]  awlen = '0, arlen = '0;
  logic [3:0]  wstrb = '0;
  logic        awvalid = 1'b0, wlast = 1'b0, wvalid = 1'b0, bready = 1'b0;
  logic        arvalid = 1'b0, rready = 1'b0;
  logic        awready, wready, bvalid, arready, rlast, rvalid;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata;

  int n_cmp = 0;
  int n_fail = 0;

  logic [31:0] ref_mem [DEPTH];
  logic [31:0] wd [256];
  logic [3:0]  ws [256];
  logic        wl [256];
  logic [31:0] rq_data [$];
  logic        rq_last [$];
  logic [1:0]  rq_resp [$];

  always #5 clk = ~clk;

  axi4_burst_slave_mem dut (
    .s00_axi_aclk    (clk),
    .s00_axi_aresetn (rst_n),
    .s00_axi_awaddr  (awaddr),
    .s00_axi_awlen   (awlen),
    .s00_axi_awvalid (awvalid),
    .s00_axi_awready (awready),
    .s00_axi_wdata   (wdata),
    .s00_axi_wstrb   (wstrb),
    .s00_axi_wlast   (wlast),
    .s00_axi_wvalid  (wvalid),
    .s00_axi_wready  (wready),
    .s00_axi_bresp   (bresp),
    .s00_axi_bvalid  (bvalid),
    .s00_axi_bready  (bready),
    .s00_axi_araddr  (araddr),
    .s00_axi_arlen   (arlen),
    .s00_axi_arvalid (arvalid),
    .s00_axi_arready (arready),
    .s00_axi_rdata   (rdata),
    .s00_axi_rresp   (rresp),
    .s00_axi_rlast   (rlast),
    .s00_axi_rvalid  (rvalid),
    .s00_axi_rready  (rready)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at %0t, required completion earlier", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Model: each beat lands at word ((addr/4)+beat) mod DEPTH, only on enabled bytes.
  function automatic void ref_write(input logic [31:0] addr, input int nbeats);
    for (int i = 0; i < nbeats; i++) begin
      int unsigned idx = ((addr >> 2) + i) % DEPTH;
      for (int b = 0; b < 4; b++)
        if (ws[i][b]) ref_mem[idx][8*b +: 8] = wd[i][8*b +: 8];
    end
  endfunction

  function automatic logic [31:0] ref_read(input logic [31:0] addr, input int beat);
    return ref_mem[((addr >> 2) + beat) % DEPTH];
  endfunction

  task automatic axi_write(input logic [31:0] addr, input int len, input int gap_pct,
                           input int abort_beat);
    int t;
    bit hs;
    awaddr = addr; awlen = 8'(len); awvalid = 1'b1; t = 0;
    forever begin
      hs = awready; tick();
      if (hs) break;
      if (++t > 200) begin
        n_cmp++; n_fail++; awvalid = 1'b0;
        $display("FAIL aw_timeout: awready actual 0 required 1 within 200 cycles");
        return;
      end
    end
    awvalid = 1'b0;
    for (int i = 0; i <= len; i++) begin
      while (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
        wvalid = 1'b0; tick();
      end
      wdata = wd[i]; wstrb = ws[i]; wlast = wl[i]; wvalid = 1'b1;
      if (i == abort_beat) begin
        #2 rst_n = 1'b0;
        return;
      end
      t = 0;
      forever begin
        hs = wready; tick();
        if (hs) break;
        if (++t > 200) begin
          n_cmp++; n_fail++; wvalid = 1'b0;
          $display("FAIL w_timeout: beat %0d wready actual 0 required 1 within 200 cycles", i);
          return;
        end
      end
    end
    wvalid = 1'b0; wlast = 1'b0;
  endtask

  task automatic axi_bresp(input int hold, output logic [1:0] resp);
    int t = 0;
    resp = 2'bxx;
    while (bvalid !== 1'b1) begin
      tick();
      if (++t > 200) begin
        n_cmp++; n_fail++;
        $display("FAIL b_timeout: bvalid actual 0 required 1 within 200 cycles");
        return;
      end
    end
    repeat (hold) tick();
    bready = 1'b1; resp = bresp;
    tick();
    bready = 1'b0;
  endtask

  task automatic axi_read(input logic [31:0] addr, input int len, input int rr_pct,
                          input int start_dly, output int stab_err, output int ncyc);
    int t, beats;
    bit hs, stalled;
    logic [31:0] pd;
    logic pl;
    rq_data.delete(); rq_last.delete(); rq_resp.delete();
    stab_err = 0; ncyc = 0; beats = 0; stalled = 0; pd = '0; pl = 1'b0;
    repeat (start_dly) tick();
    araddr = addr; arlen = 8'(len); arvalid = 1'b1; t = 0;
    forever begin
      hs = arready; tick();
      if (hs) break;
      if (++t > 200) begin
        n_cmp++; n_fail++; arvalid = 1'b0;
        $display("FAIL ar_timeout: arready actual 0 required 1 within 200 cycles");
        return;
      end
    end
    arvalid = 1'b0;
    while (beats <= len) begin
      if (rvalid === 1'b1) begin
        if (stalled && (rdata !== pd || rlast !== pl)) stab_err++;
        rready = (rr_pct >= 100) || ($urandom_range(99) < rr_pct);
        if (rready) begin
          rq_data.push_back(rdata); rq_last.push_back(rlast); rq_resp.push_back(rresp);
          beats++; stalled = 0;
        end else begin
          stalled = 1; pd = rdata; pl = rlast;
        end
      end else begin
        rready = 1'($urandom_range(1));
      end
      tick(); ncyc++;
      if (ncyc > (len + 1) * 40 + 100) begin
        n_cmp++; n_fail++; rready = 1'b0;
        $display("FAIL r_timeout: beats actual %0d required %0d", beats, len + 1);
        return;
      end
    end
    rready = 1'b0;
  endtask

  task automatic test_reset();
    logic [9:0] obs;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    obs = {awready, arready, wready, bvalid, bresp, rvalid, rlast, rresp};
    n_cmp++;
    if (obs !== 10'b11_0_0_00_0_0_00) begin
      n_fail++;
      $display("FAIL reset_outputs: actual %b required %b", obs, 10'b1100000000);
    end
    n_cmp++;
    if (rdata !== 32'h0) begin
      n_fail++; $display("FAIL reset_rdata: actual %h required 00000000", rdata);
    end
    #3 rst_n = 1'b1;
    tick();
    n_cmp++;
    if ({awready, arready} !== 2'b11) begin
      n_fail++; $display("FAIL reset_release_ready: actual %b required 11", {awready, arready});
    end
  endtask

  task automatic test_random();
    logic [31:0] addr, raddr, exp;
    logic [1:0]  resp;
    int len, rlen, stab, ncyc;
    for (int it = 0; it < 24; it++) begin
      if (it == 0) begin addr = 32'h0; len = 63; end
      else if (it == 1) begin addr = $urandom; len = 255; end
      else begin addr = $urandom; len = $urandom_range(20); end
      for (int i = 0; i <= len; i++) begin
        wd[i] = $urandom;
        ws[i] = (it == 0) ? 4'hF : 4'($urandom);
        wl[i] = (i == len);
      end
      axi_write(addr, len, (it == 0) ? 0 : 30, -1);
      axi_bresp($urandom_range(4), resp);
      ref_write(addr, len + 1);
      n_cmp++;
      if (resp !== 2'b00) begin
        n_fail++; $display("FAIL rand_bresp it=%0d: actual %b required 00", it, resp);
      end
      if (it % 2 == 0) begin raddr = addr; rlen = (len > 63) ? 63 : len; end
      else begin raddr = $urandom; rlen = $urandom_range(30); end
      axi_read(raddr, rlen, (it == 0) ? 100 : 60, 0, stab, ncyc);
      n_cmp++;
      if (rq_data.size() != rlen + 1) begin
        n_fail++;
        $display("FAIL rand_beats it=%0d: actual %0d required %0d", it, rq_data.size(), rlen + 1);
      end
      for (int b = 0; b < rq_data.size(); b++) begin
        exp = ref_read(raddr, b);
        n_cmp++;
        if (rq_data[b] !== exp || rq_last[b] !== (b == rlen) || rq_resp[b] !== 2'b00) begin
          n_fail++;
          $display("FAIL rand_rbeat it=%0d beat=%0d: actual %h/last %b/resp %b required %h/last %b/resp 00",
                   it, b, rq_data[b], rq_last[b], rq_resp[b], exp, (b == rlen));
        end
      end
      n_cmp++;
      if (stab != 0 || rvalid !== 1'b0) begin
        n_fail++;
        $display("FAIL rand_rend it=%0d: stall changes %0d rvalid %b required 0 and 0", it, stab, rvalid);
      end
    end
  endtask

  task automatic test_incr16();
    logic [1:0] resp;
    int stab, ncyc;
    for (int i = 0; i < 16; i++) begin
      wd[i] = 32'(i * 8 + 3); ws[i] = 4'hF; wl[i] = (i == 15);
    end
    axi_write(32'h4000_0000, 15, 0, -1);
    axi_bresp(0, resp);
    ref_write(32'h4000_0000, 16);
    n_cmp++;
    if (resp !== 2'b00) begin
      n_fail++; $display("FAIL incr16_bresp: actual %b required 00", resp);
    end
    axi_read(32'h4000_0000, 15, 100, 0, stab, ncyc);
    n_cmp++;
    if (rq_data.size() != 16 || ncyc != 16) begin
      n_fail++;
      $display("FAIL incr16_timing: beats %0d cycles %0d required 16 and 16", rq_data.size(), ncyc);
    end
    for (int b = 0; b < rq_data.size(); b++) begin
      n_cmp++;
      if (rq_data[b] !== 32'(b * 8 + 3) || rq_last[b] !== (b == 15)) begin
        n_fail++;
        $display("FAIL incr16_rbeat beat=%0d: actual %h/last %b required %h/last %b",
                 b, rq_data[b], rq_last[b], 32'(b * 8 + 3), (b == 15));
      end
    end
  endtask

  task automatic test_strobe();
    logic [1:0] resp;
    int stab, ncyc;
    wd[0] = 32'h1122_3344; ws[0] = 4'hF; wl[0] = 1'b1;
    axi_write(32'h0, 0, 0, -1);
    axi_bresp(1, resp);
    ref_write(32'h0, 1);
    wd[0] = 32'hAABB_CCDD; ws[0] = 4'b0011;
    axi_write(32'h0, 0, 0, -1);
    axi_bresp(0, resp);
    ref_write(32'h0, 1);
    axi_read(32'h0, 0, 100, 0, stab, ncyc);
    n_cmp++;
    if (rq_data.size() != 1 || rq_data[0] !== 32'h1122_CCDD || rq_last[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL strobe_merge: actual %h required 1122ccdd (beats %0d)",
               (rq_data.size() > 0) ? rq_data[0] : 32'hx, rq_data.size());
    end
  endtask

  task automatic test_wrap();
    logic [1:0] resp;
    int stab, ncyc;
    for (int i = 0; i < 4; i++) begin
      wd[i] = 32'(i + 1); ws[i] = 4'hF; wl[i] = (i == 3);
    end
    axi_write(32'h8000_00F8, 3, 0, -1);
    axi_bresp(0, resp);
    ref_write(32'h8000_00F8, 4);
    n_cmp++;
    if (resp !== 2'b00) begin
      n_fail++; $display("FAIL wrap_bresp: actual %b required 00", resp);
    end
    axi_read(32'h0000_00F8, 3, 100, 0, stab, ncyc);
    for (int b = 0; b < 4; b++) begin
      n_cmp++;
      if (b >= rq_data.size() || rq_data[b] !== 32'(b + 1) || rq_last[b] !== (b == 3)) begin
        n_fail++;
        $display("FAIL wrap_read62 beat=%0d: actual %h required %h",
                 b, (b < rq_data.size()) ? rq_data[b] : 32'hx, 32'(b + 1));
      end
    end
    axi_read(32'h1234_5600, 1, 100, 0, stab, ncyc);
    n_cmp++;
    if (rq_data.size() != 2 || rq_data[0] !== 32'd3 || rq_data[1] !== 32'd4) begin
      n_fail++; $display("FAIL wrap_read0: beats %0d required words 0,1 = 3,4", rq_data.size());
    end
  endtask

  task automatic test_backpressure();
    logic [1:0] resp;
    int stab, ncyc;
    for (int i = 0; i < 4; i++) begin
      wd[i] = $urandom; ws[i] = 4'hF; wl[i] = (i == 3);
    end
    axi_write(32'h0000_0020, 3, 0, -1);
    for (int k = 0; k < 5; k++) begin
      n_cmp++;
      if (bvalid !== 1'b1 || awready !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_bhold cycle=%0d: bvalid %b awready %b required 1 and 0", k, bvalid, awready);
      end
      tick();
    end
    axi_bresp(0, resp);
    ref_write(32'h0000_0020, 4);
    n_cmp++;
    if (resp !== 2'b00 || awready !== 1'b1 || bvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_bdone: bresp %b awready %b bvalid %b required 00 1 0", resp, awready, bvalid);
    end
    for (int rep = 0; rep < 3; rep++) begin
      axi_read(32'h0000_0020, 3, 50, 0, stab, ncyc);
      n_cmp++;
      if (stab != 0 || rq_data.size() != 4) begin
        n_fail++;
        $display("FAIL bp_rstall rep=%0d: stall changes %0d beats %0d required 0 and 4",
                 rep, stab, rq_data.size());
      end
      for (int b = 0; b < rq_data.size(); b++) begin
        n_cmp++;
        if (rq_data[b] !== wd[b] || rq_last[b] !== (b == 3)) begin
          n_fail++;
          $display("FAIL bp_rbeat rep=%0d beat=%0d: actual %h/last %b required %h/last %b",
                   rep, b, rq_data[b], rq_last[b], wd[b], (b == 3));
        end
      end
    end
  endtask

  task automatic test_wlast_err();
    logic [1:0] resp, exp_resp;
    int stab, ncyc;
    // case 0: early wlast, 1: clean, 2: missing wlast, 3: clean again
    for (int c = 0; c < 4; c++) begin
      for (int i = 0; i < 4; i++) begin
        wd[i] = $urandom; ws[i] = 4'hF;
        wl[i] = (c == 0) ? (i == 1) : (c == 2) ? 1'b0 : (i == 3);
      end
      exp_resp = (c == 0 || c == 2) ? 2'b10 : 2'b00;
      axi_write(32'h0000_0030, 3, 20, -1);
      axi_bresp($urandom_range(2), resp);
      ref_write(32'h0000_0030, 4);
      n_cmp++;
      if (resp !== exp_resp) begin
        n_fail++; $display("FAIL wlast_bresp case=%0d: actual %b required %b", c, resp, exp_resp);
      end
      axi_read(32'h0000_0030, 3, 100, 0, stab, ncyc);
      for (int b = 0; b < 4; b++) begin
        n_cmp++;
        if (b >= rq_data.size() || rq_data[b] !== wd[b]) begin
          n_fail++;
          $display("FAIL wlast_rbeat case=%0d beat=%0d: actual %h required %h",
                   c, b, (b < rq_data.size()) ? rq_data[b] : 32'hx, wd[b]);
        end
      end
    end
  endtask

  task automatic test_simultaneous();
    logic [1:0] resp;
    logic [31:0] old_val, exp;
    int stab, ncyc;
    for (int i = 0; i < 4; i++) begin
      wd[i] = $urandom; ws[i] = 4'hF; wl[i] = (i == 3);
    end
    fork
      axi_write(32'h0000_0040, 3, 0, -1);
      axi_read(32'h0000_00A0, 5, 100, 0, stab, ncyc);
    join
    axi_bresp(0, resp);
    ref_write(32'h0000_0040, 4);
    n_cmp++;
    if (resp !== 2'b00 || rq_data.size() != 6) begin
      n_fail++;
      $display("FAIL simul_aw_ar: bresp %b beats %0d required 00 and 6", resp, rq_data.size());
    end
    for (int b = 0; b < rq_data.size(); b++) begin
      exp = ref_read(32'h0000_00A0, b);
      n_cmp++;
      if (rq_data[b] !== exp) begin
        n_fail++; $display("FAIL simul_rbeat beat=%0d: actual %h required %h", b, rq_data[b], exp);
      end
    end
    old_val = ref_mem[50];
    wd[0] = ~old_val; ws[0] = 4'hF; wl[0] = 1'b1;
    fork
      axi_write(32'h0000_00C8, 0, 0, -1);
      axi_read(32'h0000_00C8, 0, 100, 1, stab, ncyc);
    join
    axi_bresp(0, resp);
    ref_write(32'h0000_00C8, 1);
    n_cmp++;
    if (rq_data.size() != 1 || rq_data[0] !== old_val) begin
      n_fail++;
      $display("FAIL simul_old_value: actual %h required %h",
               (rq_data.size() > 0) ? rq_data[0] : 32'hx, old_val);
    end
    axi_read(32'h0000_00C8, 0, 100, 0, stab, ncyc);
    n_cmp++;
    if (rq_data.size() != 1 || rq_data[0] !== ~old_val) begin
      n_fail++;
      $display("FAIL simul_new_value: actual %h required %h",
               (rq_data.size() > 0) ? rq_data[0] : 32'hx, ~old_val);
    end
  endtask

  task automatic test_reset_mid_burst();
    logic [1:0] resp;
    logic [5:0] obs;
    logic [31:0] exp;
    int stab, ncyc;
    for (int i = 0; i < 16; i++) begin
      wd[i] = $urandom; ws[i] = 4'hF; wl[i] = (i == 15);
    end
    axi_write(32'h0000_0080, 15, 0, 5);
    #1;
    obs = {awready, arready, wready, bvalid, rvalid, rlast};
    n_cmp++;
    if (obs !== 6'b110000) begin
      n_fail++; $display("FAIL abort_outputs: actual %b required 110000", obs);
    end
    wvalid = 1'b0; wlast = 1'b0;
    #3 rst_n = 1'b1;
    tick();
    ref_write(32'h0000_0080, 5);
    for (int i = 0; i < 4; i++) begin
      wd[i] = $urandom; ws[i] = 4'hF; wl[i] = (i == 3);
    end
    axi_write(32'h0000_0028, 3, 0, -1);
    axi_bresp(0, resp);
    ref_write(32'h0000_0028, 4);
    n_cmp++;
    if (resp !== 2'b00) begin
      n_fail++; $display("FAIL abort_next_bresp: actual %b required 00", resp);
    end
    axi_read(32'h0000_0080, 15, 80, 0, stab, ncyc);
    n_cmp++;
    if (rq_data.size() != 16) begin
      n_fail++; $display("FAIL abort_read_beats: actual %0d required 16", rq_data.size());
    end
    for (int b = 0; b < rq_data.size(); b++) begin
      exp = ref_read(32'h0000_0080, b);
      n_cmp++;
      if (rq_data[b] !== exp) begin
        n_fail++; $display("FAIL abort_rbeat beat=%0d: actual %h required %h", b, rq_data[b], exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_random();
    test_incr16();
    test_strobe();
    test_wrap();
    test_backpressure();
    test_wlast_err();
    test_simultaneous();
    test_reset_mid_burst();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
